// File: rtl/magnitude_search.sv
// Successive-approximation search that drives a trial operand into an external
// magnitude comparator. Optional macro MAGNITUDE_SEARCH_CHECK_EN flags non-one-hot verdicts.
module magnitude_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_guess;
    logic [WIDTH-1:0] r_result;
    logic             r_found;
    logic             r_err;

    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] w_lo_next;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_guess_next;
    logic [WIDTH-1:0] w_result_next;
    logic             w_found_next;
    logic             w_err_next;

    logic             w_illegal;
    logic             w_take_eq;
    logic             w_take_gt;
    logic             w_take_lt;

    // Midpoint sums carry one extra bit so lo+hi never wraps before the halving.
    logic [WIDTH:0]   w_sum_init;
    logic [WIDTH:0]   w_sum_up;
    logic [WIDTH:0]   w_sum_dn;
    logic [WIDTH-1:0] w_mid_init;
    logic [WIDTH-1:0] w_mid_up;
    logic [WIDTH-1:0] w_mid_dn;

    assign w_sum_init = {1'b0, ALL_ONES};
    assign w_sum_up   = {1'b0, r_guess} + (WIDTH+1)'(1) + {1'b0, r_hi};
    assign w_sum_dn   = {1'b0, r_lo} + {1'b0, r_guess} - (WIDTH+1)'(1);
    assign w_mid_init = WIDTH'(w_sum_init >> 1);
    assign w_mid_up   = WIDTH'(w_sum_up >> 1);
    assign w_mid_dn   = WIDTH'(w_sum_dn >> 1);

`ifdef MAGNITUDE_SEARCH_CHECK_EN
    // Exactly one of three: odd parity rules out two set, the AND rules out all three.
    assign w_illegal = ~((gt ^ lt ^ eq) & ~(gt & lt & eq));
    assign w_take_eq = eq;
    assign w_take_gt = gt;
    assign w_take_lt = lt;
`else
    // Fixed priority eq > gt > lt; an empty verdict falls through to lt.
    assign w_illegal = 1'b0;
    assign w_take_eq = eq;
    assign w_take_gt = ~eq & gt;
    assign w_take_lt = ~eq & ~gt;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_lo_next     = r_lo;
        w_hi_next     = r_hi;
        w_guess_next  = r_guess;
        w_result_next = r_result;
        w_found_next  = r_found;
        w_err_next    = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_lo_next    = '0;
                    w_hi_next    = ALL_ONES;
                    w_guess_next = w_mid_init;
                    w_state_next = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_illegal) begin
                    w_found_next = 1'b0;
                    w_err_next   = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_take_eq) begin
                    w_result_next = r_guess;
                    w_found_next  = 1'b1;
                    w_err_next    = 1'b0;
                    w_state_next  = S_DONE;
                end else if (w_take_gt) begin
                    if (r_guess == r_hi) begin
                        w_found_next = 1'b0;
                        w_err_next   = 1'b0;
                        w_state_next = S_DONE;
                    end else begin
                        w_lo_next    = r_guess + WIDTH'(1);
                        w_guess_next = w_mid_up;
                    end
                end else if (w_take_lt) begin
                    if (r_guess == r_lo) begin
                        w_found_next = 1'b0;
                        w_err_next   = 1'b0;
                        w_state_next = S_DONE;
                    end else begin
                        w_hi_next    = r_guess - WIDTH'(1);
                        w_guess_next = w_mid_dn;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= ALL_ONES;
            r_guess  <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_lo     <= w_lo_next;
            r_hi     <= w_hi_next;
            r_guess  <= w_guess_next;
            r_result <= w_result_next;
            r_found  <= w_found_next;
            r_err    <= w_err_next;
        end
    end

    assign guess  = r_guess;
    assign busy   = (r_state == S_SEARCH);
    assign done   = (r_state == S_DONE);
    assign found  = r_found;
    assign result = r_result;
    assign err    = r_err;

endmodule

// File: doc/magnitude_search.md
# magnitude_search

Successive-approximation search engine that finds an unknown value by repeatedly driving a trial value into an external magnitude comparator and steering on its GT/LT/EQ verdict. It is the driving side of the comparator interface: the comparator consumes two operands and emits a verdict, and this block issues operand B and consumes the verdict. It sits beside a 4-bit comparator whose A input holds the unknown target, and it returns the recovered value with a done pulse.

## Interface
Parameters:
- WIDTH, 4, operand width; search range 0 .. 2^WIDTH-1

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new search; accepted only in IDLE
- guess  output  WIDTH  trial value driven to comparator operand B (registered)
- gt  input  1  comparator verdict: target > guess (combinational from guess)
- lt  input  1  comparator verdict: target < guess
- eq  input  1  comparator verdict: target == guess
- busy  output  1  high in SEARCH
- done  output  1  one-cycle pulse in DONE
- found  output  1  valid with done; 1 = result holds the target
- result  output  WIDTH  recovered value; holds until next done
- err  output  1  valid with done; illegal verdict seen (see Configuration)

## Operation
- Registers: lo, hi (WIDTH bits), guess, result, found, err, state.
- States: IDLE, SEARCH, DONE.
- IDLE: start=1 -> lo=0, hi=2^WIDTH-1, guess=(0+hi)>>1, go to SEARCH. guess holds its last value while idle.
- SEARCH: each cycle sample the gt/lt/eq verdict for the current guess.
  - eq: result=guess, found=1, go to DONE.
  - gt: if guess==hi -> found=0, go to DONE; else lo=guess+1, guess=(guess+1+hi)>>1.
  - lt: if guess==lo -> found=0, go to DONE; else hi=guess-1, guess=(lo+guess-1)>>1.
- Midpoint sum is computed at WIDTH+1 bits, then shifted right by 1. No wrap-around is permitted.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while busy or in DONE is ignored. No queueing.
- Reset in any state, including mid-search: next state is IDLE. guess, result, lo, busy, done, found and err are 0; hi is all-ones.

## Timing
- Start is sampled at cycle 0. The first guess is on the port at cycle 1.
- Each probe takes 1 cycle. At most WIDTH+1 probes are needed.
- done is asserted one cycle after the deciding probe. Latency from start is probes+1 cycles, at most WIDTH+2.
- The comparator must settle within the same cycle, from guess to gt/lt/eq.
- busy rises the cycle after start. busy and done are never high together.
- found, result and err are stable from done onward until the next done.

## Configuration
- Macro: MAGNITUDE_SEARCH_CHECK_EN.
- Defined: a verdict that is not one-hot (none set, or two or more set) during SEARCH ends the search.
  - The block goes to DONE with found=0 and err=1. result keeps its previous value.
- Undefined: err is tied to 0. Verdict priority is eq > gt > lt, and an all-zero verdict is treated as lt.

## Test plan
- Target 7, start at cycle 0 -> guess=7 at cycle 1. At cycle 2: done=1, found=1, result=7. busy is high only at cycle 1.
- Target 15 -> guess sequence 7, 11, 13, 14, 15. At cycle 6: done=1, found=1, result=15.
- Target 0 -> guess sequence 7, 3, 1, 0. At cycle 5: done=1, found=1, result=0. Exercises the lower bound with no underflow.
- Inconsistent model: comparator always answers gt -> guesses 7, 11, 13, 14, 15. At cycle 6: done=1, found=0, result unchanged.
- With MAGNITUDE_SEARCH_CHECK_EN: gt=lt=1 at cycle 1 -> at cycle 2: done=1, err=1, found=0. Without the macro, the same stimulus gives lo=8 and continues searching.
- rst asserted at cycle 3 of a search for target 15 -> at cycle 4 all outputs are 0 and state is IDLE. A new start then finds 15 normally. A start pulse while busy is ignored and does not change the guess sequence.
